// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - HI/LO multiply sequencer wrapped around the combinational multU
// Optional signed-product correction is enabled by defining HILO_SIGNED_MULT_EN.
module hilo_unit #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               is_signed,
  output logic [WIDTH-1:0]   mult_a,
  output logic [WIDTH-1:0]   mult_b,
  input  logic [2*WIDTH-1:0] mult_product,
  input  logic               mthi,
  input  logic               mtlo,
  input  logic [WIDTH-1:0]   wdata,
  input  logic               rd_req,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               busy,
  output logic               done,
  output logic               stall
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, WRITE} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic               signed_q;
  logic [2*WIDTH-1:0] result;

`ifdef HILO_SIGNED_MULT_EN
  // multU is unsigned; subtract the cross terms a negative operand contributes
  always_comb begin
    result = mult_product;
    if (signed_q) begin
      if (mult_a[WIDTH-1]) result = result - {mult_b, {WIDTH{1'b0}}};
      if (mult_b[WIDTH-1]) result = result - {mult_a, {WIDTH{1'b0}}};
    end
  end
`else
  logic unused_signed;
  assign unused_signed = signed_q;
  assign result        = mult_product;
`endif

  assign stall = rd_req & busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      signed_q <= 1'b0;
      mult_a   <= '0;
      mult_b   <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (mthi) hi <= wdata;
          if (mtlo) lo <= wdata;
          if (start) begin
            mult_a   <= op_a;
            mult_b   <= op_b;
            signed_q <= is_signed;
            count    <= CW'(LATENCY - 1);
            busy     <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (count == '0) state <= WRITE;
          else             count <= count - CW'(1);
        end
        WRITE: begin
          hi    <= result[2*WIDTH-1:WIDTH];
          lo    <= result[WIDTH-1:0];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_unit.sv
// tb/tb_hilo_unit.sv - randomized and directed bench for hilo_unit against a cycle-count model
module tb_hilo_unit;
  localparam int W   = 32;
  localparam int LAT = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   op_a = '0, op_b = '0, wdata = '0;
  logic           is_signed = 1'b0, mthi = 1'b0, mtlo = 1'b0, rd_req = 1'b0;
  logic [W-1:0]   mult_a, mult_b, hi, lo;
  logic [2*W-1:0] mult_product;
  logic           busy, done, stall;

  hilo_unit #(.WIDTH(W), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
    .is_signed(is_signed), .mult_a(mult_a), .mult_b(mult_b),
    .mult_product(mult_product), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .rd_req(rd_req), .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  // stand-in for multU
  assign mult_product = {{W{1'b0}}, mult_a} * {{W{1'b0}}, mult_b};

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b,
                                              input logic s);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
`ifdef HILO_SIGNED_MULT_EN
    if (s) p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
`else
    if (s) p = {32'b0, a} * {32'b0, b};
`endif
    return p;
  endfunction

  // model: a job is accepted in idle and lands LAT+1 edges later
  logic [31:0] m_a = '0, m_b = '0, m_hi = '0, m_lo = '0;
  logic        m_sgn = 1'b0, m_done = 1'b0;
  int          rem = 0;

  always @(posedge clk or posedge reset) begin
    logic [63:0] p;
    if (reset) begin
      m_a = '0; m_b = '0; m_hi = '0; m_lo = '0; m_sgn = 1'b0; m_done = 1'b0; rem = 0;
    end else begin
      m_done = 1'b0;
      if (rem == 0) begin
        if (mthi) m_hi = wdata;
        if (mtlo) m_lo = wdata;
        if (start) begin
          m_a = op_a; m_b = op_b; m_sgn = is_signed; rem = LAT + 1;
        end
      end else begin
        rem--;
        if (rem == 0) begin
          p = ref_product(m_a, m_b, m_sgn);
          m_hi = p[63:32]; m_lo = p[31:0]; m_done = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("mult_a", {32'b0, mult_a}, {32'b0, m_a});
    check("mult_b", {32'b0, mult_b}, {32'b0, m_b});
    check("hi", {32'b0, hi}, {32'b0, m_hi});
    check("lo", {32'b0, lo}, {32'b0, m_lo});
    check("busy", {63'b0, busy}, {63'b0, rem != 0});
    check("done", {63'b0, done}, {63'b0, m_done});
    check("stall", {63'b0, stall}, {63'b0, rd_req && rem != 0});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    op_a = a; op_b = b; is_signed = s; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 50) begin
      tick();
      n++;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    int dones;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_hi", {32'b0, hi}, 64'h0);
    check("rst_lo", {32'b0, lo}, 64'h0);
    check("rst_busy", {63'b0, busy}, 64'h0);

    issue(32'd4, 32'd4, 1'b0);
    check("t1_mult_a", {32'b0, mult_a}, 64'd4);
    check("t1_mult_b", {32'b0, mult_b}, 64'd4);
    check("t1_busy", {63'b0, busy}, 64'd1);
    wait_done(n);
    check("t1_latency", n, LAT + 1);
    check("t1_hi", {32'b0, hi}, 64'h0);
    check("t1_lo", {32'b0, lo}, 64'h10);
    check("t1_busy_low", {63'b0, busy}, 64'd0);

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done(n);
    check("t2_latency", n, LAT + 1);
    check("t2_hi", {32'b0, hi}, 64'hFFFF_FFFE);
    check("t2_lo", {32'b0, lo}, 64'h1);

    tick();
    issue(32'd4, 32'd4, 1'b0);
    tick();
    issue(32'd7, 32'd7, 1'b0);
    check("t3_mult_a", {32'b0, mult_a}, 64'd4);
    wait_done(n);
    check("t3_latency", n, LAT - 1);
    check("t3_hi", {32'b0, hi}, 64'h0);
    check("t3_lo", {32'b0, lo}, 64'h10);
    check("t3_mult_a_end", {32'b0, mult_a}, 64'd4);

    tick();
    mthi = 1'b1; wdata = 32'hDEAD_BEEF;
    tick();
    mthi = 1'b0;
    check("t4_hi", {32'b0, hi}, 64'hDEAD_BEEF);
    check("t4_lo", {32'b0, lo}, 64'h10);
    check("t4_idle_stall", {63'b0, stall}, 64'd0);
    issue(32'd3, 32'd5, 1'b0);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1234_5678; rd_req = 1'b1;
    tick();
    check("t4_busy_hi", {32'b0, hi}, 64'hDEAD_BEEF);
    check("t4_busy_lo", {32'b0, lo}, 64'h10);
    check("t4_stall", {63'b0, stall}, 64'd1);
    mthi = 1'b0; mtlo = 1'b0;
    wait_done(n);
    check("t4_hi_prod", {32'b0, hi}, 64'h0);
    check("t4_lo_prod", {32'b0, lo}, 64'd15);
    check("t4_stall_done", {63'b0, stall}, 64'd0);
    rd_req = 1'b0;

    issue(32'd9, 32'd9, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    check("t5_hi", {32'b0, hi}, 64'h0);
    check("t5_lo", {32'b0, lo}, 64'h0);
    check("t5_busy", {63'b0, busy}, 64'd0);
    tick();
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) dones++;
    end
    check("t5_no_done", dones, 0);
    issue(32'd6, 32'd7, 1'b0);
    wait_done(n);
    check("t5_latency", n, LAT + 1);
    check("t5_lo", {32'b0, lo}, 64'd42);

    issue(32'hFFFF_FFFC, 32'd4, 1'b1);
    wait_done(n);
`ifdef HILO_SIGNED_MULT_EN
    check("t6_hi", {32'b0, hi}, 64'hFFFF_FFFF);
`else
    check("t6_hi", {32'b0, hi}, 64'h3);
`endif
    check("t6_lo", {32'b0, lo}, 64'hFFFF_FFF0);

    for (int i = 0; i < 600; i++) begin
      op_a      = pick();
      op_b      = pick();
      wdata     = $urandom;
      is_signed = $urandom_range(0, 1) == 1;
      start     = $urandom_range(0, 3) == 0;
      mthi      = $urandom_range(0, 7) == 0;
      mtlo      = $urandom_range(0, 7) == 0;
      rd_req    = $urandom_range(0, 1) == 1;
      reset     = $urandom_range(0, 149) == 0;
      tick();
    end
    reset = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; rd_req = 1'b0;
    repeat (LAT + 4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
